// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: decodes RV32I integer ALU instructions into a one-hot ALU
// select, resolves forwarded operands and registers them behind a valid/ready handshake.
module id_ex_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [31:0] id_inst,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic        mem_fwd_we,
    input  logic [4:0]  mem_fwd_rd,
    input  logic [31:0] mem_fwd_data,
    input  logic        wb_fwd_we,
    input  logic [4:0]  wb_fwd_rd,
    input  logic [31:0] wb_fwd_data,
    input  logic        flush,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [11:0] ex_alu_control,
    output logic [31:0] ex_alu_src1,
    output logic [31:0] ex_alu_src2,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_rd,
    output logic        ex_rf_we,
    output logic        ex_illegal
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [4:0]  rd_idx;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    logic [11:0] dec_ctrl;
    logic [31:0] dec_src1;
    logic [31:0] dec_src2;
    logic        dec_legal;
    logic        is_shift;
    logic        accept;

    assign opcode  = id_inst[6:0];
    assign rd_idx  = id_inst[11:7];
    assign funct3  = id_inst[14:12];
    assign rs1_idx = id_inst[19:15];
    assign rs2_idx = id_inst[24:20];
    assign funct7  = id_inst[31:25];
    assign imm_i   = {{20{id_inst[31]}}, id_inst[31:20]};
    assign imm_u   = {id_inst[31:12], 12'd0};

    // x0 is hard-wired; EX/MEM is younger than MEM/WB and therefore wins.
    assign rs1_val = (rs1_idx == 5'd0)                          ? 32'd0        :
                     (mem_fwd_we && (mem_fwd_rd == rs1_idx))    ? mem_fwd_data :
                     (wb_fwd_we  && (wb_fwd_rd  == rs1_idx))    ? wb_fwd_data  :
                                                                  id_rs1_data;
    assign rs2_val = (rs2_idx == 5'd0)                          ? 32'd0        :
                     (mem_fwd_we && (mem_fwd_rd == rs2_idx))    ? mem_fwd_data :
                     (wb_fwd_we  && (wb_fwd_rd  == rs2_idx))    ? wb_fwd_data  :
                                                                  id_rs2_data;

    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        dec_ctrl  = '0;
        dec_src1  = '0;
        dec_src2  = '0;
        dec_legal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_src1 = rs1_val;
                dec_src2 = rs2_val;
                if (funct7 == F7_BASE) begin
                    dec_legal = 1'b1;
                    case (funct3)
                        3'b000:  dec_ctrl[ALU_ADD]  = 1'b1;
                        3'b001:  dec_ctrl[ALU_SLL]  = 1'b1;
                        3'b010:  dec_ctrl[ALU_SLT]  = 1'b1;
                        3'b011:  dec_ctrl[ALU_SLTU] = 1'b1;
                        3'b100:  dec_ctrl[ALU_XOR]  = 1'b1;
                        3'b101:  dec_ctrl[ALU_SRL]  = 1'b1;
                        3'b110:  dec_ctrl[ALU_OR]   = 1'b1;
                        default: dec_ctrl[ALU_AND]  = 1'b1;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_legal          = 1'b1;
                    dec_ctrl[ALU_SUB]  = 1'b1;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_legal          = 1'b1;
                    dec_ctrl[ALU_SRA]  = 1'b1;
                end
                // The ALU shifts src2 by src1[4:0], so operands swap for shifts.
                if (is_shift) begin
                    dec_src1 = rs2_val;
                    dec_src2 = rs1_val;
                end
            end
            OPC_OPIMM: begin
                dec_src1 = rs1_val;
                dec_src2 = imm_i;
                case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_ctrl[ALU_ADD]  = 1'b1; end
                    3'b010: begin dec_legal = 1'b1; dec_ctrl[ALU_SLT]  = 1'b1; end
                    3'b011: begin dec_legal = 1'b1; dec_ctrl[ALU_SLTU] = 1'b1; end
                    3'b100: begin dec_legal = 1'b1; dec_ctrl[ALU_XOR]  = 1'b1; end
                    3'b110: begin dec_legal = 1'b1; dec_ctrl[ALU_OR]   = 1'b1; end
                    3'b111: begin dec_legal = 1'b1; dec_ctrl[ALU_AND]  = 1'b1; end
                    3'b001: begin
                        if (funct7 == F7_BASE) begin
                            dec_legal         = 1'b1;
                            dec_ctrl[ALU_SLL] = 1'b1;
                        end
                    end
                    default: begin
                        if (funct7 == F7_BASE) begin
                            dec_legal         = 1'b1;
                            dec_ctrl[ALU_SRL] = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            dec_legal         = 1'b1;
                            dec_ctrl[ALU_SRA] = 1'b1;
                        end
                    end
                endcase
                if (is_shift) begin
                    dec_src1 = {27'd0, rs2_idx};
                    dec_src2 = rs1_val;
                end
            end
            OPC_LUI: begin
                dec_legal         = 1'b1;
                dec_ctrl[ALU_ADD] = 1'b1;
                dec_src2          = imm_u;
            end
            OPC_AUIPC: begin
                dec_legal         = 1'b1;
                dec_ctrl[ALU_ADD] = 1'b1;
                dec_src1          = id_pc;
                dec_src2          = imm_u;
            end
            default: ;
        endcase
    end

    assign id_ready = !ex_valid || ex_ready;
    assign accept   = id_valid && id_ready && !flush;

    // Flush beats everything; a consumed slot empties unless refilled on the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_valid <= 1'b0;
        end else if (flush) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid <= 1'b1;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_alu_control <= '0;
            ex_alu_src1    <= '0;
            ex_alu_src2    <= '0;
            ex_pc          <= '0;
            ex_rd          <= '0;
            ex_rf_we       <= 1'b0;
            ex_illegal     <= 1'b0;
        end else if (accept) begin
            ex_alu_control <= dec_ctrl;
            ex_alu_src1    <= dec_src1;
            ex_alu_src2    <= dec_src2;
            ex_pc          <= id_pc;
            ex_rd          <= rd_idx;
            ex_rf_we       <= dec_legal && (rd_idx != 5'd0);
            ex_illegal     <= !dec_legal;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instructions push expected EX contents,
// a monitor pops and compares each time the EX slot is consumed.
module tb_id_ex_stage;

    logic        clk;
    logic        resetn;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic        mem_fwd_we;
    logic [4:0]  mem_fwd_rd;
    logic [31:0] mem_fwd_data;
    logic        wb_fwd_we;
    logic [4:0]  wb_fwd_rd;
    logic [31:0] wb_fwd_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [11:0] ex_alu_control;
    logic [31:0] ex_alu_src1;
    logic [31:0] ex_alu_src2;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd;
    logic        ex_rf_we;
    logic        ex_illegal;

    typedef struct {
        logic [11:0] ctrl;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
        logic        chk_src;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    id_ex_stage dut (
        .clk            (clk),
        .resetn         (resetn),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_rs1_data    (id_rs1_data),
        .id_rs2_data    (id_rs2_data),
        .mem_fwd_we     (mem_fwd_we),
        .mem_fwd_rd     (mem_fwd_rd),
        .mem_fwd_data   (mem_fwd_data),
        .wb_fwd_we      (wb_fwd_we),
        .wb_fwd_rd      (wb_fwd_rd),
        .wb_fwd_data    (wb_fwd_data),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_alu_control (ex_alu_control),
        .ex_alu_src1    (ex_alu_src1),
        .ex_alu_src2    (ex_alu_src2),
        .ex_pc          (ex_pc),
        .ex_rd          (ex_rd),
        .ex_rf_we       (ex_rf_we),
        .ex_illegal     (ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [11:0] ctrl, input logic [31:0] s1, input logic [31:0] s2,
                                input logic [31:0] pc, input logic [4:0] rd, input logic we,
                                input logic ill, input logic chk_src);
        exp_t e;
        e.ctrl = ctrl; e.src1 = s1; e.src2 = s2; e.pc = pc;
        e.rd = rd; e.we = we; e.ill = ill; e.chk_src = chk_src;
        return e;
    endfunction

    // Monitor: the slot is consumed on the coming edge when valid and ready are both high.
    always @(negedge clk) begin
        if (resetn && ex_valid && ex_ready) begin
            if (sb.size() == 0) begin
                check("mon_unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mon_ctrl", {20'd0, ex_alu_control}, {20'd0, e.ctrl});
                if (e.chk_src) begin
                    check("mon_src1", ex_alu_src1, e.src1);
                    check("mon_src2", ex_alu_src2, e.src2);
                end
                check("mon_pc", ex_pc, e.pc);
                check("mon_rd", {27'd0, ex_rd}, {27'd0, e.rd});
                check("mon_rf_we", {31'd0, ex_rf_we}, {31'd0, e.we});
                check("mon_illegal", {31'd0, ex_illegal}, {31'd0, e.ill});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one instruction and hold it until the stage accepts it.
    task automatic send(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2, input exp_t e);
        logic acc;
        int   waited;
        id_inst = inst; id_pc = pc; id_rs1_data = r1; id_rs2_data = r2;
        id_valid = 1'b1;
        sb.push_back(e);
        waited = 0;
        forever begin
            @(negedge clk);
            acc = id_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 50) begin
                check("accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        id_valid = 1'b0;
    endtask

    task automatic clear_fwd();
        mem_fwd_we = 1'b0; mem_fwd_rd = 5'd0; mem_fwd_data = 32'd0;
        wb_fwd_we  = 1'b0; wb_fwd_rd  = 5'd0; wb_fwd_data  = 32'd0;
    endtask

    initial begin
        resetn = 1'b0; id_valid = 1'b0; id_inst = 32'd0; id_pc = 32'd0;
        id_rs1_data = 32'd0; id_rs2_data = 32'd0; flush = 1'b0; ex_ready = 1'b1;
        clear_fwd();

        #12;
        check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_id_ready", {31'd0, id_ready}, 32'd1);
        check("rst_ctrl", {20'd0, ex_alu_control}, 32'd0);
        check("rst_src1", ex_alu_src1, 32'd0);
        check("rst_src2", ex_alu_src2, 32'd0);
        check("rst_rf_we", {31'd0, ex_rf_we}, 32'd0);
        check("rst_illegal", {31'd0, ex_illegal}, 32'd0);
        #6 resetn = 1'b1;
        @(posedge clk); #1;

        // Back-to-back stream with ex_ready held high.
        send(32'h003100B3, 32'h0000_0000, 32'd5, 32'd7,
             mk(12'h001, 32'd5, 32'd7, 32'h0, 5'd1, 1'b1, 1'b0, 1'b1));          // add x1,x2,x3
        send(32'h4030D093, 32'h0000_0004, 32'hF000_0000, 32'h0000_1234,
             mk(12'h400, 32'd3, 32'hF000_0000, 32'h4, 5'd1, 1'b1, 1'b0, 1'b1));  // srai x1,x1,3
        send(32'h12345037, 32'h0000_0008, 32'h55, 32'h66,
             mk(12'h001, 32'd0, 32'h1234_5000, 32'h8, 5'd0, 1'b0, 1'b0, 1'b1));  // lui x0
        send(32'h12345297, 32'h0000_0100, 32'h55, 32'h66,
             mk(12'h001, 32'h100, 32'h1234_5000, 32'h100, 5'd5, 1'b1, 1'b0, 1'b1)); // auipc x5
        send(32'h40310233, 32'h0000_0010, 32'd10, 32'd3,
             mk(12'h002, 32'd10, 32'd3, 32'h10, 5'd4, 1'b1, 1'b0, 1'b1));        // sub
        send(32'h003110B3, 32'h0000_0014, 32'h11, 32'd4,
             mk(12'h100, 32'd4, 32'h11, 32'h14, 5'd1, 1'b1, 1'b0, 1'b1));        // sll
        send(32'hFFF3C313, 32'h0000_0018, 32'h0F0F_0F0F, 32'd0,
             mk(12'h080, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'h18, 5'd6, 1'b1, 1'b0, 1'b1)); // xori -1
        send(32'h00513093, 32'h0000_001C, 32'd2, 32'd0,
             mk(12'h008, 32'd2, 32'd5, 32'h1C, 5'd1, 1'b1, 1'b0, 1'b1));         // sltiu
        send(32'h02310233, 32'h0000_0020, 32'd1, 32'd2,
             mk(12'h000, 32'd0, 32'd0, 32'h20, 5'd4, 1'b0, 1'b1, 1'b0));         // mul: illegal
        send(32'h00000073, 32'h0000_0024, 32'd1, 32'd2,
             mk(12'h000, 32'd0, 32'd0, 32'h24, 5'd0, 1'b0, 1'b1, 1'b0));         // ecall: illegal

        // Forwarding: EX/MEM beats MEM/WB; x0 ignores both; MEM/WB alone on rs2.
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd2; mem_fwd_data = 32'hAA;
        wb_fwd_we  = 1'b1; wb_fwd_rd  = 5'd2; wb_fwd_data  = 32'hBB;
        send(32'h00310233, 32'h0000_0030, 32'd5, 32'd7,
             mk(12'h001, 32'hAA, 32'd7, 32'h30, 5'd4, 1'b1, 1'b0, 1'b1));
        mem_fwd_rd = 5'd0; wb_fwd_rd = 5'd0;
        send(32'h00300233, 32'h0000_0034, 32'd5, 32'd7,
             mk(12'h001, 32'd0, 32'd7, 32'h34, 5'd4, 1'b1, 1'b0, 1'b1));
        mem_fwd_rd = 5'd5; wb_fwd_rd = 5'd3;
        send(32'h00310233, 32'h0000_0038, 32'd5, 32'd7,
             mk(12'h001, 32'd5, 32'hBB, 32'h38, 5'd4, 1'b1, 1'b0, 1'b1));
        clear_fwd();
        idle(2);

        // Stall: A held for 3 cycles while B waits, then B enters on the release edge.
        ex_ready = 1'b0;
        send(32'h003100B3, 32'h0000_0200, 32'd5, 32'd7,
             mk(12'h001, 32'd5, 32'd7, 32'h200, 5'd1, 1'b1, 1'b0, 1'b1));
        id_inst = 32'h00A4E433; id_pc = 32'h204; id_rs1_data = 32'h0F0; id_rs2_data = 32'h00F;
        id_valid = 1'b1;
        sb.push_back(mk(12'h040, 32'h0F0, 32'h00F, 32'h204, 5'd8, 1'b1, 1'b0, 1'b1)); // or x8,x9,x10
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_id_ready", {31'd0, id_ready}, 32'd0);
            check("stall_ex_valid", {31'd0, ex_valid}, 32'd1);
            check("stall_src1", ex_alu_src1, 32'd5);
            check("stall_src2", ex_alu_src2, 32'd7);
            check("stall_pc", ex_pc, 32'h200);
            @(posedge clk); #1;
        end
        ex_ready = 1'b1;
        @(negedge clk);
        check("release_id_ready", {31'd0, id_ready}, 32'd1);
        @(posedge clk); #1;
        id_valid = 1'b0;
        check("release_b_loaded", ex_pc, 32'h204);
        idle(2);

        // Flush of an incoming instruction with the EX slot empty.
        id_inst = 32'h003100B3; id_pc = 32'h300; id_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("flush_idle_id_ready", {31'd0, id_ready}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; id_valid = 1'b0;
        check("flush_idle_ex_valid", {31'd0, ex_valid}, 32'd0);

        // Flush of a held instruction plus an incoming one.
        ex_ready = 1'b0;
        send(32'h003100B3, 32'h0000_0400, 32'd1, 32'd2,
             mk(12'h001, 32'd1, 32'd2, 32'h400, 5'd1, 1'b1, 1'b0, 1'b1));
        sb.delete(sb.size() - 1);
        id_inst = 32'h40310233; id_pc = 32'h404; id_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("flush_held_id_ready", {31'd0, id_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; id_valid = 1'b0;
        check("flush_held_ex_valid", {31'd0, ex_valid}, 32'd0);
        ex_ready = 1'b1;
        idle(2);

        // Reset asserted while stalled.
        ex_ready = 1'b0;
        send(32'h00513093, 32'h0000_0500, 32'd9, 32'd0,
             mk(12'h008, 32'd9, 32'd5, 32'h500, 5'd1, 1'b1, 1'b0, 1'b1));
        sb.delete(sb.size() - 1);
        @(negedge clk);
        check("pre_reset_ex_valid", {31'd0, ex_valid}, 32'd1);
        resetn = 1'b0;
        #1;
        check("mid_reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("mid_reset_ctrl", {20'd0, ex_alu_control}, 32'd0);
        check("mid_reset_src1", ex_alu_src1, 32'd0);
        check("mid_reset_pc", ex_pc, 32'd0);
        check("mid_reset_id_ready", {31'd0, id_ready}, 32'd1);
        @(posedge clk); #1;
        resetn = 1'b1;
        ex_ready = 1'b1;
        idle(3);
        check("post_reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
